// File: rtl/sound_pkg.sv
// ---------------------------------------------------------------------------
// sound_pkg
// Shared definitions for the game sound path: event codes (code value is also
// the priority, higher wins), arbiter states, the tone table (half-period in
// clocks, duration in video frames) and a priority picker.
// ---------------------------------------------------------------------------
package sound_pkg;

    typedef enum logic [1:0] {
        EV_TICK    = 2'd0,
        EV_EAT     = 2'd1,
        EV_SUCCESS = 2'd2,
        EV_FAILURE = 2'd3
    } event_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    // Indexed by event code.
    localparam int HALF_PERIOD [4] = '{6294, 12588, 8392, 62938};
    localparam int DURATION    [4] = '{1, 6, 30, 60};

    // Highest set code in v; EV_TICK when v is empty (callers qualify with |v).
    function automatic event_e highest(input logic [3:0] v);
        if (v[3])      return EV_FAILURE;
        else if (v[2]) return EV_SUCCESS;
        else if (v[1]) return EV_EAT;
        else           return EV_TICK;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// ---------------------------------------------------------------------------
// tone_gen
// Square-wave generator: a half-period counter that runs 0..half-1 and toggles
// the tone bit on each wrap. restart_i zeroes the counter and forces the tone
// high; enable_i low parks the generator with the tone low.
// The next-cycle tone value is exported so the parent can register it together
// with its own gating without adding a cycle of latency.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   enable_i       generator running (next cycle)
//   restart_i      start a new tone (counter 0, tone 1)
//   half_i         half-period in clocks, must be >= 1
//   tone_nxt_o     tone bit that will be held after this clock edge
// ---------------------------------------------------------------------------
module tone_gen #(
    parameter int HALF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic              restart_i,
    input  logic [HALF_W-1:0] half_i,
    output logic              tone_nxt_o
);

    logic [HALF_W-1:0] cnt_q, cnt_d;
    logic              tone_q, tone_d;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cnt_d  = cnt_q + HALF_W'(1);
        tone_d = tone_q;
        if (!enable_i) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (restart_i) begin
            cnt_d  = '0;
            tone_d = 1'b1;
        end else if (cnt_q == half_i - HALF_W'(1)) begin
            cnt_d  = '0;
            tone_d = ~tone_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone_nxt_o = tone_d;

endmodule

// File: rtl/sound_arbiter.sv
// ---------------------------------------------------------------------------
// sound_arbiter
// Shares the single audio pin between the four game events. One-cycle request
// pulses are arbitrated by fixed priority; the winner plays its square wave
// for a table number of video frames. Lower requests wait in pending latches,
// higher requests preempt (the preempted tone is dropped), a repeat of the
// playing event reloads its duration without disturbing the phase.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   i_tick/i_eat/i_success/i_failure request pulses (codes 0..3)
//   i_frame                          one pulse per video frame
//   i_mute                           level; forces o_audio low
//   o_audio                          registered square wave
//   o_active                         tone playing
//   o_event                          code playing, valid with o_active
// ---------------------------------------------------------------------------
module sound_arbiter
    import sound_pkg::*;
#(
    parameter int SIM_DIV_SHIFT = 0,
    parameter int HALF_W        = 16,
    parameter int DUR_W         = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick,
    input  logic       i_eat,
    input  logic       i_success,
    input  logic       i_failure,
    input  logic       i_frame,
    input  logic       i_mute,
    output logic       o_audio,
    output logic       o_active,
    output logic [1:0] o_event
);

    // Table entries that do not fit the counters stop elaboration.
    for (genvar i = 0; i < 4; i++) begin : g_tbl_chk
        if ((HALF_PERIOD[i] >> HALF_W) != 0) begin : g_half_fatal
            $fatal(1, "sound_arbiter: HALF_PERIOD entry exceeds HALF_W");
        end
        if ((DURATION[i] >> DUR_W) != 0) begin : g_dur_fatal
            $fatal(1, "sound_arbiter: DURATION entry exceeds DUR_W");
        end
    end

    function automatic logic [HALF_W-1:0] eff_half(input event_e e);
        int h;
        h = HALF_PERIOD[e] >> SIM_DIV_SHIFT;
        if (h < 1) h = 1;
        return h[HALF_W-1:0];
    endfunction

    function automatic logic [DUR_W-1:0] dur_of(input event_e e);
        int d;
        d = DURATION[e];
        return d[DUR_W-1:0];
    endfunction

    state_e           state_q, state_d;
    event_e           cur_q, cur_d;
    logic [3:0]       pending_q, pending_d;
    logic [DUR_W-1:0] rem_q, rem_d;
    logic             audio_q;

    logic [3:0] req, cand;
    event_e     req_top, cand_top;
    logic       start;
    logic       tone_nxt;

    assign req      = {i_failure, i_success, i_eat, i_tick};
    assign cand     = req | pending_q;
    assign req_top  = highest(req);
    assign cand_top = highest(cand);

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        rem_d     = rem_q;
        pending_d = pending_q | req;
        start     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|cand) start = 1'b1;
            end
            ST_PLAY: begin
                // Pending bits are always below cur, so a higher request is
                // also the top candidate.
                if (|req && (req_top > cur_q)) begin
                    start = 1'b1;
                end else if (req[cur_q]) begin
                    // Retrigger: a coinciding frame is not counted.
                    rem_d            = dur_of(cur_q);
                    pending_d[cur_q] = 1'b0;
                end else if (i_frame) begin
                    if (rem_q == DUR_W'(1)) begin
                        if (|cand) start = 1'b1;
                        else       state_d = ST_IDLE;
                    end else begin
                        rem_d = rem_q - DUR_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start) begin
            state_d             = ST_PLAY;
            cur_d               = cand_top;
            rem_d               = dur_of(cand_top);
            pending_d[cand_top] = 1'b0;
        end
    end

    tone_gen #(
        .HALF_W (HALF_W)
    ) u_tone (
        .clk        (clk),
        .rst        (rst),
        .enable_i   (state_d == ST_PLAY),
        .restart_i  (start),
        .half_i     (eff_half(cur_d)),
        .tone_nxt_o (tone_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cur_q     <= EV_TICK;
            pending_q <= '0;
            rem_q     <= '0;
            audio_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            pending_q <= pending_d;
            rem_q     <= rem_d;
            audio_q   <= tone_nxt & ~i_mute;
        end
    end

    assign o_audio  = audio_q;
    assign o_active = (state_q == ST_PLAY);
    assign o_event  = cur_q;

endmodule
